// File: rtl/div_pkg.sv
// Shared types and constants for the shared-divider controller.
package div_pkg;
    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = {WIDTH{1'b1}};
    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;
endpackage

// File: rtl/divider_4bit.sv
// Combinational unsigned 4-bit divider; a zero divisor yields zeros (the controller overrides).
module divider_4bit
    import div_pkg::*;
(
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (divisor != '0) begin
            quotient  = dividend / divisor;
            remainder = dividend % divisor;
        end
    end
endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin front end time-sharing one divider_4bit between two requesters,
// with a tagged, back-pressured response register.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_id,
    output logic             rsp_div0,
    output logic             busy
);
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t           state;
    logic [WIDTH-1:0] op_dividend;
    logic [WIDTH-1:0] op_divisor;
    logic             op_id;
    logic             last_grant;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             grant;

    divider_4bit u_divider (
        .dividend  (op_dividend),
        .divisor   (op_divisor),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // A tie goes to whoever did not win last; last_grant resets to 1 so req0 wins first.
    always_comb begin
        grant = ID_REQ0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = ID_REQ1;
        end
    end

    assign req0_ready = (state == ST_IDLE) && req0_valid && (grant == ID_REQ0);
    assign req1_ready = (state == ST_IDLE) && req1_valid && (grant == ID_REQ1);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op_dividend   <= '0;
            op_divisor    <= '0;
            op_id         <= ID_REQ0;
            last_grant    <= ID_REQ1;
            cnt           <= '0;
            rsp_valid     <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_id        <= 1'b0;
            rsp_div0      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_dividend <= req1_ready ? req1_dividend : req0_dividend;
                        op_divisor  <= req1_ready ? req1_divisor : req0_divisor;
                        op_id       <= grant;
                        last_grant  <= grant;
                        cnt         <= CNT_LOAD;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= op_id;
                        if (op_divisor == '0) begin
                            rsp_quotient  <= DIV0_QUOTIENT;
                            rsp_remainder <= op_dividend;
                            rsp_div0      <= 1'b1;
                        end else begin
                            rsp_quotient  <= div_quotient;
                            rsp_remainder <= div_remainder;
                            rsp_div0      <= 1'b0;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
Two-requester controller that time-shares one combinational divider_4bit datapath. It arbitrates round-robin between two valid/ready request channels and registers the granted operands into the divider. After a programmable settle time it captures quotient and remainder, and presents them on a single tagged response channel with backpressure. Divide-by-zero is detected and reported with fixed result values.

Parameters:
WIDTH, 4, operand/result width; fixed to the divider_4bit width.
EXEC_CYCLES, 1, cycles from operand acceptance to result capture; legal range 1..15.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_dividend  input  WIDTH  requester 0 dividend
req0_divisor  input  WIDTH  requester 0 divisor
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_dividend  input  WIDTH  requester 1 dividend
req1_divisor  input  WIDTH  requester 1 divisor
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_quotient  output  WIDTH  quotient
rsp_remainder  output  WIDTH  remainder
rsp_id  output  1  requester that issued this result
rsp_div0  output  1  divisor was zero
busy  output  1  operation in flight (state != IDLE)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: rsp_valid=0, rsp_quotient=0, rsp_remainder=0, rsp_id=0, rsp_div0=0, busy=0, state=IDLE, operand registers=0, last_grant=1. last_grant=1 means requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Only one reqN_valid high: grant N.
  - Both high: grant the requester that is not last_grant.
- IDLE, ready and acceptance:
  - reqN_ready = (state==IDLE) & reqN_valid & (grant==N), combinational.
  - At most one ready is high in any cycle.
  - On handshake, register dividend, divisor and id, load cnt=EXEC_CYCLES-1, and go to EXEC.
  - Set last_grant=N at acceptance.
- EXEC:
  - Registered operands drive divider_4bit.
  - If cnt!=0, decrement cnt.
  - If cnt==0, capture results into the rsp_* registers, set rsp_valid=1, and go to RESP.
- Latency: acceptance at edge T gives rsp_valid=1 after edge T+EXEC_CYCLES.
- Divide-by-zero: when the registered divisor==0, capture rsp_quotient={WIDTH{1}}, rsp_remainder=dividend, rsp_div0=1, ignoring the divider outputs. Otherwise rsp_div0=0.
- RESP:
  - rsp_* hold stable while rsp_valid & !rsp_ready.
  - Both req ready outputs are 0.
  - On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE. Data registers keep their last values.
- No bypass: the earliest next acceptance is the cycle after the response handshake. Minimum period per operation is EXEC_CYCLES+2 cycles with rsp_ready held high.
- Requester rule: operands stay stable while valid is high and ready is low. The controller never drops a pending valid and makes no starvation-free guarantee beyond alternation.
- Reset mid-operation: all state clears immediately, the in-flight result is discarded, and rsp_valid drops asynchronously.
- Widths: arithmetic is unsigned WIDTH bits; cnt is 4 bits.

Decomposition:
- Shared package div_pkg holds:
  - WIDTH=4
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2
  - DIV0_QUOTIENT={WIDTH{1}}
  - ID_REQ0=0, ID_REQ1=1
- Sub-module: the existing divider_4bit, instantiated once and fed from the registered operands.
- Arbiter, FSM and response registers stay in div_share_ctrl. No further split.

Test Plan:
- req0 13/4 alone, rsp_ready=1, EXEC_CYCLES=1 -> req0_ready one cycle, then next cycle rsp_valid with q=3, r=1, id=0, div0=0. Rerun with EXEC_CYCLES=3 -> rsp_valid 3 cycles after acceptance.
- Right after reset, req0 9/2 and req1 15/5 valid together -> req0 granted first (q=4, r=1, id=0), then req1 (q=3, r=0, id=1).
- Both requesters held valid continuously for 6 ops -> rsp_id sequence 0,1,0,1,0,1.
- Divide-by-zero: req1 7/0 -> q=15, r=7, div0=1, id=1.
- Backpressure: rsp_ready low for 5 cycles with result 11/3 pending -> q=3, r=2 held stable, busy=1, both req ready=0. Raising rsp_ready gives a handshake, and the next acceptance occurs no earlier than the following cycle.
- rst_n pulsed low during EXEC -> rsp_valid and busy 0 immediately, no response emitted. A following tie is granted to req0.
